control_sequencer: RTL and testbench



---
 rtl/cpu_defs_pkg.sv | 39 +++
 rtl/instr_class_decode.sv | 15 +
 rtl/control_sequencer.sv | 126 ++++++++++++
 tb/tb_control_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: opcodes, sequencer state encoding and instruction classes for the control unit.
package cpu_defs_pkg;
  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd24;
  localparam logic [4:0] OP_HALT = 5'd25;
  localparam logic [3:0] S_RESET = 4'd0;
  localparam logic [3:0] S_T0    = 4'd1;
  localparam logic [3:0] S_T1    = 4'd2;
  localparam logic [3:0] S_T2    = 4'd3;
  localparam logic [3:0] S_T3    = 4'd4;
  localparam logic [3:0] S_T4    = 4'd5;
  localparam logic [3:0] S_T5    = 4'd6;
  localparam logic [3:0] S_T6    = 4'd7;
  localparam logic [3:0] S_T7    = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;
  typedef enum logic [2:0] {
    CL_ALU,
    CL_MULDIV,
    CL_LD,
    CL_LDI,
    CL_ST,
    CL_BR,
    CL_NOP,
    CL_HALT
  } instr_class_t;
endpackage

// File: rtl/instr_class_decode.sv
// instr_class_decode: maps an opcode onto the execute sequence it needs; unknown opcodes behave as nop.
module instr_class_decode
  import cpu_defs_pkg::*;
(
  input  logic [4:0]   opcode,
  output instr_class_t cls
);
  assign cls = (opcode >= OP_ADD && opcode <= OP_ROL)   ? CL_ALU    :
               (opcode == OP_MUL || opcode == OP_DIV)   ? CL_MULDIV :
               (opcode == OP_LD)                        ? CL_LD     :
               (opcode == OP_LDI)                       ? CL_LDI    :
               (opcode == OP_ST)                        ? CL_ST     :
               (opcode == OP_BR)                        ? CL_BR     :
               (opcode == OP_HALT)                      ? CL_HALT   : CL_NOP;
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle hardwired T-state control unit for the single-bus datapath.
module control_sequencer
  import cpu_defs_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [31:0]    ir,
  input  logic           con_ff,
  input  logic           mem_ready,
  input  logic           stop,
  output logic           pc_out,
  output logic           zhigh_out,
  output logic           zlow_out,
  output logic           mdr_out,
  output logic           c_out,
  output logic           ba_out,
  output logic           gra,
  output logic           grb,
  output logic           grc,
  output logic           r_in,
  output logic           r_out,
  output logic           pc_in,
  output logic           mar_in,
  output logic           mdr_in,
  output logic           ir_in,
  output logic           y_in,
  output logic           hi_in,
  output logic           lo_in,
  output logic           zhi_in,
  output logic           zlo_in,
  output logic           con_in,
  output logic           inc_pc,
  output logic           read,
  output logic           write,
  output logic [OPW-1:0] operation,
  output logic           run
);
  logic [3:0]   state, nxt;
  instr_class_t cls;
  logic         unused_ir;
  assign unused_ir = ^ir[31-OPW:0];
  instr_class_decode u_decode (
    .opcode(ir[31:27]),
    .cls   (cls)
  );
  always_comb begin
    nxt = state;
    case (state)
      S_RESET: nxt = S_T0;
      S_T0:    nxt = S_T1;
      S_T1:    nxt = mem_ready ? S_T2 : S_T1;
      S_T2:    nxt = cls == CL_HALT ? S_HALT : cls == CL_NOP ? S_T0 : S_T3;
      S_T3:    nxt = S_T4;
      S_T4:    nxt = S_T5;
      S_T5:    nxt = (cls == CL_ALU || cls == CL_LDI) ? S_T0 : S_T6;
      S_T6:    nxt = cls == CL_LD ? (mem_ready ? S_T7 : S_T6) : cls == CL_ST ? S_T7 : S_T0;
      S_T7:    nxt = (cls == CL_ST && !mem_ready) ? S_T7 : S_T0;
      default: nxt = S_HALT;
    endcase
    // the only way into T0 is an instruction boundary, so stop is honoured here
    if (nxt == S_T0 && stop) nxt = S_HALT;
  end
  always_ff @(posedge clk)
    state <= clr ? S_RESET : nxt;
  assign run = state != S_RESET && state != S_HALT;
  always_comb begin
    {pc_out, zhigh_out, zlow_out, mdr_out, c_out, ba_out} = '0;
    {gra, grb, grc, r_in, r_out} = '0;
    {pc_in, mar_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhi_in, zlo_in, con_in} = '0;
    {inc_pc, read, write} = '0;
    operation = '0;
    case (state)
      S_T0: {pc_out, mar_in, inc_pc, zlo_in} = '1;
      S_T1: {zlow_out, pc_in, read, mdr_in} = '1;
      S_T2: {mdr_out, ir_in} = '1;
      S_T3: case (cls)
        CL_ALU:              {grb, r_out, y_in} = '1;
        CL_MULDIV:           {gra, r_out, y_in} = '1;
        CL_LD, CL_LDI, CL_ST: {grb, ba_out, y_in} = '1;
        CL_BR:               {gra, r_out, con_in} = '1;
        default: ;
      endcase
      S_T4: case (cls)
        CL_ALU: begin
          {grc, r_out, zlo_in} = '1;
          operation = ir[31 -: OPW];
        end
        CL_MULDIV: begin
          {grb, r_out, zlo_in, zhi_in} = '1;
          operation = ir[31 -: OPW];
        end
        CL_LD, CL_LDI, CL_ST: begin
          {c_out, zlo_in} = '1;
          operation = OPW'(OP_ADD);
        end
        CL_BR: {pc_out, y_in} = '1;
        default: ;
      endcase
      S_T5: case (cls)
        CL_ALU, CL_LDI: {zlow_out, gra, r_in} = '1;
        CL_MULDIV:      {zlow_out, lo_in} = '1;
        CL_LD, CL_ST:   {zlow_out, mar_in} = '1;
        CL_BR: begin
          {c_out, zlo_in} = '1;
          operation = OPW'(OP_ADD);
        end
        default: ;
      endcase
      S_T6: case (cls)
        CL_MULDIV: {zhigh_out, hi_in} = '1;
        CL_LD:     {read, mdr_in} = '1;
        CL_ST:     {gra, r_out, mdr_in} = '1;
        CL_BR:     {zlow_out, pc_in} = {2{con_ff}};
        default: ;
      endcase
      S_T7: case (cls)
        CL_LD:   {mdr_out, gra, r_in} = '1;
        CL_ST:   write = 1'b1;
        default: ;
      endcase
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed per-cycle checks of strobes and operation against hand-built step tables.
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] ir = '0;
  logic        con_ff = 1'b0;
  logic        mem_ready = 1'b1;
  logic        stop = 1'b0;
  logic pc_out, zhigh_out, zlow_out, mdr_out, c_out, ba_out;
  logic gra, grb, grc, r_in, r_out;
  logic pc_in, mar_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhi_in, zlo_in, con_in;
  logic inc_pc, read, write, run;
  logic [4:0] operation;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready), .stop(stop),
    .pc_out(pc_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out), .mdr_out(mdr_out),
    .c_out(c_out), .ba_out(ba_out), .gra(gra), .grb(grb), .grc(grc), .r_in(r_in),
    .r_out(r_out), .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in),
    .y_in(y_in), .hi_in(hi_in), .lo_in(lo_in), .zhi_in(zhi_in), .zlo_in(zlo_in),
    .con_in(con_in), .inc_pc(inc_pc), .read(read), .write(write),
    .operation(operation), .run(run)
  );
  wire [24:0] sig = {run, inc_pc, read, write, pc_in, mar_in, mdr_in, ir_in, y_in, hi_in,
                     lo_in, zhi_in, zlo_in, con_in, gra, grb, grc, r_in, r_out, pc_out,
                     zhigh_out, zlow_out, mdr_out, c_out, ba_out};
  localparam logic [24:0] M_BA_OUT = 25'd1 << 0, M_C_OUT = 25'd1 << 1, M_MDR_OUT = 25'd1 << 2;
  localparam logic [24:0] M_ZLOW_OUT = 25'd1 << 3, M_ZHIGH_OUT = 25'd1 << 4, M_PC_OUT = 25'd1 << 5;
  localparam logic [24:0] M_R_OUT = 25'd1 << 6, M_R_IN = 25'd1 << 7, M_GRC = 25'd1 << 8;
  localparam logic [24:0] M_GRB = 25'd1 << 9, M_GRA = 25'd1 << 10, M_CON_IN = 25'd1 << 11;
  localparam logic [24:0] M_ZLO_IN = 25'd1 << 12, M_ZHI_IN = 25'd1 << 13, M_LO_IN = 25'd1 << 14;
  localparam logic [24:0] M_HI_IN = 25'd1 << 15, M_Y_IN = 25'd1 << 16, M_IR_IN = 25'd1 << 17;
  localparam logic [24:0] M_MDR_IN = 25'd1 << 18, M_MAR_IN = 25'd1 << 19, M_PC_IN = 25'd1 << 20;
  localparam logic [24:0] M_WRITE = 25'd1 << 21, M_READ = 25'd1 << 22, M_INC_PC = 25'd1 << 23;
  localparam logic [24:0] M_RUN = 25'd1 << 24;
  localparam logic [24:0] E_T0 = M_PC_OUT | M_MAR_IN | M_INC_PC | M_ZLO_IN | M_RUN;
  localparam logic [24:0] E_T1 = M_ZLOW_OUT | M_PC_IN | M_READ | M_MDR_IN | M_RUN;
  localparam logic [24:0] E_T2 = M_MDR_OUT | M_IR_IN | M_RUN;
  localparam logic [24:0] E_MEMA3 = M_GRB | M_BA_OUT | M_Y_IN | M_RUN;
  localparam logic [24:0] E_MEMA4 = M_C_OUT | M_ZLO_IN | M_RUN;
  // step word: {expected strobes[24:0], expected operation[4:0], mem_ready, stop} driven after the check
  task automatic test_reset();
    clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (sig !== 25'd0 || operation !== 5'd0) begin
        bad++;
        $display("FAIL reset cycle %0d: got sig=%h op=%0d want sig=0 op=0", i, sig, operation);
      end
    end
    clr = 1'b0;
    @(negedge clk);
    total++;
    if (sig !== E_T0 || operation !== 5'd0) begin
      bad++;
      $display("FAIL reset_to_t0: got sig=%h op=%0d want sig=%h op=0", sig, operation, E_T0);
    end
  endtask
  task automatic test_fetch_wait();
    logic [31:0] s [6];
    s = '{{E_T1, 5'd0, 2'b00}, {E_T1, 5'd0, 2'b00}, {E_T1, 5'd0, 2'b00}, {E_T1, 5'd0, 2'b10},
          {E_T2, 5'd0, 2'b10}, {E_T0, 5'd0, 2'b10}};
    ir = 32'hC000_0000;
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (sig !== s[i][31:7] || operation !== s[i][6:2]) begin
        bad++;
        $display("FAIL fetch_wait step %0d: got sig=%h op=%0d want sig=%h op=%0d", i, sig, operation, s[i][31:7], s[i][6:2]);
      end
      mem_ready = s[i][1];
      stop = s[i][0];
    end
  endtask
  task automatic test_add();
    logic [31:0] s [6];
    s = '{{E_T1, 5'd0, 2'b10}, {E_T2, 5'd0, 2'b10}, {M_GRB | M_R_OUT | M_Y_IN | M_RUN, 5'd0, 2'b10},
          {M_GRC | M_R_OUT | M_ZLO_IN | M_RUN, 5'd3, 2'b10},
          {M_ZLOW_OUT | M_GRA | M_R_IN | M_RUN, 5'd0, 2'b10}, {E_T0, 5'd0, 2'b10}};
    ir = 32'h1800_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (sig !== s[i][31:7] || operation !== s[i][6:2]) begin
        bad++;
        $display("FAIL add step %0d: got sig=%h op=%0d want sig=%h op=%0d", i, sig, operation, s[i][31:7], s[i][6:2]);
      end
      mem_ready = s[i][1];
      stop = s[i][0];
    end
  endtask
  task automatic test_ldi();
    logic [31:0] s [6];
    s = '{{E_T1, 5'd0, 2'b10}, {E_T2, 5'd0, 2'b10}, {E_MEMA3, 5'd0, 2'b10}, {E_MEMA4, 5'd3, 2'b10},
          {M_ZLOW_OUT | M_GRA | M_R_IN | M_RUN, 5'd0, 2'b10}, {E_T0, 5'd0, 2'b10}};
    ir = 32'h0800_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (sig !== s[i][31:7] || operation !== s[i][6:2]) begin
        bad++;
        $display("FAIL ldi step %0d: got sig=%h op=%0d want sig=%h op=%0d", i, sig, operation, s[i][31:7], s[i][6:2]);
      end
      mem_ready = s[i][1];
      stop = s[i][0];
    end
  endtask
  task automatic test_branch(input logic cf);
    logic [31:0] s [7];
    s = '{{E_T1, 5'd0, 2'b10}, {E_T2, 5'd0, 2'b10}, {M_GRA | M_R_OUT | M_CON_IN | M_RUN, 5'd0, 2'b10},
          {M_PC_OUT | M_Y_IN | M_RUN, 5'd0, 2'b10}, {E_MEMA4, 5'd3, 2'b10},
          {(cf ? (M_ZLOW_OUT | M_PC_IN) : 25'd0) | M_RUN, 5'd0, 2'b10}, {E_T0, 5'd0, 2'b10}};
    ir = 32'h9000_0000;
    con_ff = cf;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (sig !== s[i][31:7] || operation !== s[i][6:2]) begin
        bad++;
        $display("FAIL branch cf=%0d step %0d: got sig=%h op=%0d want sig=%h op=%0d", cf, i, sig, operation, s[i][31:7], s[i][6:2]);
      end
      mem_ready = s[i][1];
      stop = s[i][0];
    end
  endtask
  task automatic test_st_then_mul();
    logic [31:0] s [10];
    logic [31:0] m [6];
    s = '{{E_T1, 5'd0, 2'b10}, {E_T2, 5'd0, 2'b10}, {E_MEMA3, 5'd0, 2'b10}, {E_MEMA4, 5'd3, 2'b10},
          {M_ZLOW_OUT | M_MAR_IN | M_RUN, 5'd0, 2'b10}, {M_GRA | M_R_OUT | M_MDR_IN | M_RUN, 5'd0, 2'b10},
          {M_WRITE | M_RUN, 5'd0, 2'b00}, {M_WRITE | M_RUN, 5'd0, 2'b00}, {M_WRITE | M_RUN, 5'd0, 2'b10},
          {E_T0, 5'd0, 2'b10}};
    m = '{{E_T1, 5'd0, 2'b10}, {E_T2, 5'd0, 2'b10}, {M_GRA | M_R_OUT | M_Y_IN | M_RUN, 5'd0, 2'b10},
          {M_GRB | M_R_OUT | M_ZLO_IN | M_ZHI_IN | M_RUN, 5'd15, 2'b10},
          {M_ZLOW_OUT | M_LO_IN | M_RUN, 5'd0, 2'b10}, {M_ZHIGH_OUT | M_HI_IN | M_RUN, 5'd0, 2'b10}};
    ir = 32'h1000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (sig !== s[i][31:7] || operation !== s[i][6:2] || (read && write)) begin
        bad++;
        $display("FAIL st step %0d: got sig=%h op=%0d want sig=%h op=%0d", i, sig, operation, s[i][31:7], s[i][6:2]);
      end
      mem_ready = s[i][1];
      stop = s[i][0];
    end
    ir = 32'h7800_0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      total++;
      if (sig !== m[i][31:7] || operation !== m[i][6:2]) begin
        bad++;
        $display("FAIL mul step %0d: got sig=%h op=%0d want sig=%h op=%0d", i, sig, operation, m[i][31:7], m[i][6:2]);
      end
      mem_ready = m[i][1];
      stop = m[i][0];
    end
    @(negedge clk);
    total++;
    if (sig !== E_T0 || operation !== 5'd0) begin
      bad++;
      $display("FAIL mul_return: got sig=%h op=%0d want sig=%h op=0", sig, operation, E_T0);
    end
  endtask
  task automatic test_ld_stop();
    logic [31:0] s [10];
    s = '{{E_T1, 5'd0, 2'b10}, {E_T2, 5'd0, 2'b10}, {E_MEMA3, 5'd0, 2'b11}, {E_MEMA4, 5'd3, 2'b11},
          {M_ZLOW_OUT | M_MAR_IN | M_RUN, 5'd0, 2'b11}, {M_READ | M_MDR_IN | M_RUN, 5'd0, 2'b01},
          {M_READ | M_MDR_IN | M_RUN, 5'd0, 2'b11}, {M_MDR_OUT | M_GRA | M_R_IN | M_RUN, 5'd0, 2'b11},
          {25'd0, 5'd0, 2'b10}, {25'd0, 5'd0, 2'b10}};
    ir = 32'h0000_0000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (sig !== s[i][31:7] || operation !== s[i][6:2]) begin
        bad++;
        $display("FAIL ld_stop step %0d: got sig=%h op=%0d want sig=%h op=%0d", i, sig, operation, s[i][31:7], s[i][6:2]);
      end
      mem_ready = s[i][1];
      stop = s[i][0];
    end
  endtask
  task automatic test_clr_mid();
    logic [31:0] s [7];
    s = '{{E_T0, 5'd0, 2'b10}, {E_T1, 5'd0, 2'b10}, {E_T2, 5'd0, 2'b10}, {E_MEMA3, 5'd0, 2'b10},
          {E_MEMA4, 5'd3, 2'b10}, {M_ZLOW_OUT | M_MAR_IN | M_RUN, 5'd0, 2'b00},
          {M_READ | M_MDR_IN | M_RUN, 5'd0, 2'b00}};
    ir = 32'h0000_0000;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++;
    if (sig !== 25'd0 || operation !== 5'd0) begin
      bad++;
      $display("FAIL clr_from_halt: got sig=%h op=%0d want sig=0 op=0", sig, operation);
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      total++;
      if (sig !== s[i][31:7] || operation !== s[i][6:2]) begin
        bad++;
        $display("FAIL clr_mid step %0d: got sig=%h op=%0d want sig=%h op=%0d", i, sig, operation, s[i][31:7], s[i][6:2]);
      end
      mem_ready = s[i][1];
      stop = s[i][0];
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mem_ready = 1'b1;
    total++;
    if (sig !== 25'd0 || operation !== 5'd0) begin
      bad++;
      $display("FAIL clr_mid_t6: got sig=%h op=%0d want sig=0 op=0", sig, operation);
    end
    @(negedge clk);
    total++;
    if (sig !== E_T0 || operation !== 5'd0) begin
      bad++;
      $display("FAIL clr_mid_restart: got sig=%h op=%0d want sig=%h op=0", sig, operation, E_T0);
    end
  endtask
  task automatic test_halt_opcode();
    logic [31:0] s [4];
    s = '{{E_T1, 5'd0, 2'b10}, {E_T2, 5'd0, 2'b10}, {25'd0, 5'd0, 2'b10}, {25'd0, 5'd0, 2'b10}};
    ir = 32'hC800_0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (sig !== s[i][31:7] || operation !== s[i][6:2]) begin
        bad++;
        $display("FAIL halt_op step %0d: got sig=%h op=%0d want sig=%h op=%0d", i, sig, operation, s[i][31:7], s[i][6:2]);
      end
      mem_ready = s[i][1];
      stop = s[i][0];
    end
  endtask
  initial begin
    test_reset();
    test_fetch_wait();
    test_add();
    test_ldi();
    test_branch(1'b0);
    test_branch(1'b1);
    test_st_then_mul();
    test_ld_stop();
    test_clr_mid();
    test_halt_opcode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
